// File: rtl/shift_rows_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_stream_if
// Description : Valid/ready stream bundle for the ShiftRows/InvShiftRows stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_rows_stream_if #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
);
    localparam int LW = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [0:32*NB-1]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [0:32*NB-1]  out_data;
    logic              out_inv;
    logic [LW-1:0]     level;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inv, level
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inv, level
    );
endinterface
`default_nettype wire

// File: rtl/shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_stream
// Description : Registered ShiftRows/InvShiftRows stage (NB = 4/6/8) with a
//               small output FIFO and valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    shift_rows_stream_if.slave      bus
);
    localparam int W  = 32 * NB;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
    if (DEPTH < 2 || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("shift_rows_stream: DEPTH must be a power of two >= 2");
    end

    // Rijndael row offsets; only the 8-column block shifts rows 2/3 by one extra.
    function automatic int row_shift(input int r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    logic [0:W-1] w_perm_fwd;
    logic [0:W-1] w_perm_inv;
    logic [0:W-1] w_perm;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S   = row_shift(r);
            localparam int FWD = 4 * ((c + S) % NB) + r;
            localparam int INV = 4 * ((c - S + NB) % NB) + r;
            assign w_perm_fwd[8*(4*c+r) +: 8] = bus.in_data[8*FWD +: 8];
            assign w_perm_inv[8*(4*c+r) +: 8] = bus.in_data[8*INV +: 8];
        end
    end

    assign w_perm = bus.in_inv ? w_perm_inv : w_perm_fwd;

    logic [0:W-1]     mem_q [DEPTH];
    logic [0:W-1]     mem_d [DEPTH];
    logic [DEPTH-1:0] inv_q, inv_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             rst_q;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // in_ready looks only at registered state so no ready path runs through the stage.
    assign w_in_ready  = (level_q < DEPTH_LVL) & ~rst_q;
    assign w_out_valid = (level_q != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_comb begin
        mem_d    = mem_q;
        inv_d    = inv_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = w_perm;
            inv_d[wr_ptr_q] = bus.in_inv;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            inv_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            inv_q    <= inv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_inv   = inv_q[rd_ptr_q];
    assign bus.level     = level_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows_stream
// Description : Self-checking bench driving NB=4/6/8 instances in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows_stream;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_rows_stream_if #(.NB(4), .DEPTH(DEPTH)) if4 ();
    shift_rows_stream_if #(.NB(6), .DEPTH(DEPTH)) if6 ();
    shift_rows_stream_if #(.NB(8), .DEPTH(DEPTH)) if8 ();

    shift_rows_stream #(.NB(4), .DEPTH(DEPTH)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    shift_rows_stream #(.NB(6), .DEPTH(DEPTH)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));
    shift_rows_stream #(.NB(8), .DEPTH(DEPTH)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    logic         in_valid  = 1'b0;
    logic         in_inv    = 1'b0;
    logic         out_ready = 1'b0;
    logic [0:127] d4 = '0;
    logic [0:191] d6 = '0;
    logic [0:255] d8 = '0;

    assign if4.in_valid = in_valid;  assign if6.in_valid = in_valid;  assign if8.in_valid = in_valid;
    assign if4.in_inv   = in_inv;    assign if6.in_inv   = in_inv;    assign if8.in_inv   = in_inv;
    assign if4.out_ready = out_ready; assign if6.out_ready = out_ready; assign if8.out_ready = out_ready;
    assign if4.in_data  = d4;        assign if6.in_data  = d6;        assign if8.in_data  = d8;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    bit check_en = 0;
    bit rst_last = 1;

    typedef struct {
        logic         inv;
        logic [0:127] a;
        logic [0:191] b;
        logic [0:255] c;
    } beat_t;
    beat_t mq[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: each row is rotated as a byte queue, left for forward, right for inverse.
    function automatic logic [0:255] permute(input int nb, input logic inv, input logic [0:255] din);
        logic [0:255] o;
        logic [7:0]   row[$];
        int           s;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            row.delete();
            for (int c = 0; c < nb; c++) row.push_back(din[8*(4*c+r) +: 8]);
            s = (nb == 8 && r >= 2) ? r + 1 : r;
            repeat (s) begin
                if (!inv) row.push_back(row.pop_front());
                else      row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [0:255] rnd256();
        logic [0:255] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard monitor: compares every cycle against the queue model.
    always @(negedge clk) begin
        logic         exp_rdy;
        logic [0:255] e;
        beat_t        h;
        exp_rdy = (mq.size() < DEPTH) && !rst_last;
        if (check_en) begin
            chk("out_valid", 256'({if4.out_valid, if6.out_valid, if8.out_valid}), 256'({3{mq.size() != 0}}));
            chk("level", 256'({if4.level, if6.level, if8.level}), 256'({3{LW'(mq.size())}}));
            chk("in_ready", 256'({if4.in_ready, if6.in_ready, if8.in_ready}), 256'({3{exp_rdy}}));
            if (mq.size() != 0) begin
                h = mq[0];
                chk("out_inv", 256'({if4.out_inv, if6.out_inv, if8.out_inv}), 256'({3{h.inv}}));
                e = permute(4, h.inv, {h.a, 128'b0});
                chk("data_nb4", 256'(if4.out_data), 256'(e[0:127]));
                e = permute(6, h.inv, {h.b, 64'b0});
                chk("data_nb6", 256'(if6.out_data), 256'(e[0:191]));
                e = permute(8, h.inv, h.c);
                chk("data_nb8", 256'(if8.out_data), 256'(e));
            end
        end
        if (rst) begin
            mq.delete();
            rst_last = 1;
        end else begin
            if (mq.size() != 0 && out_ready) begin
                void'(mq.pop_front());
                pops++;
            end
            if (in_valid && exp_rdy) mq.push_back('{in_inv, d4, d6, d8});
            rst_last = 0;
        end
    end

    task automatic push(input logic inv, input logic [0:127] a, input logic [0:191] b, input logic [0:255] c);
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_inv = inv; d4 = a; d6 = b; d8 = c;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = if4.in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("push_timeout", 256'(0), 256'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic reset_state_checks(input string tag);
        chk({tag, "_out_valid"}, 256'({if4.out_valid, if6.out_valid, if8.out_valid}), 256'(0));
        chk({tag, "_level"}, 256'({if4.level, if6.level, if8.level}), 256'(0));
        chk({tag, "_in_ready"}, 256'({if4.in_ready, if6.in_ready, if8.in_ready}), 256'(0));
        chk({tag, "_out_data"}, 256'(if8.out_data) | 256'(if6.out_data) | 256'(if4.out_data), 256'(0));
        chk({tag, "_out_inv"}, 256'({if4.out_inv, if6.out_inv, if8.out_inv}), 256'(0));
    endtask

    typedef struct {
        logic         inv;
        logic [0:255] din;
        logic [0:127] exp4;
        logic [0:31]  exp8c0;
        bit           has8;
    } vec_t;

    initial begin
        vec_t         vt[3];
        logic [0:255] r, f8, g;
        logic [0:191] f6;
        logic [0:127] f4, held;
        logic [0:255] cnt;
        int           p0;

        cnt = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vt[0] = '{1'b0, cnt, 128'h00050a0f04090e03080d02070c01060b, 32'h00050e13, 1'b1};
        vt[1] = '{1'b1, {128'h00050a0f04090e03080d02070c01060b, 128'h0},
                  128'h000102030405060708090a0b0c0d0e0f, 32'h0, 1'b0};
        vt[2] = '{1'b1, cnt, 128'h000d0a0704010e0b0805020f0c090603, 32'h001d1613, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1;
        reset_state_checks("reset");
        @(posedge clk); #1;
        chk("reset_ready_rise", 256'(if4.in_ready), 256'(1));

        // Known vectors, checked one cycle after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = vt[i].din;
            push(vt[i].inv, r[0:127], r[0:191], r);
            chk("vec_latency", 256'(if4.out_valid), 256'(1));
            chk("vec_nb4", 256'(if4.out_data), 256'(vt[i].exp4));
            chk("vec_inv", 256'(if4.out_inv), 256'(vt[i].inv));
            if (vt[i].has8) chk("vec_nb8_col0", 256'(if8.out_data[0:31]), 256'(vt[i].exp8c0));
        end
        drain();

        // Forward then inverse must restore the input for every NB.
        for (int it = 0; it < 3; it++) begin
            r = (it == 0) ? cnt : rnd256();
            out_ready = 1'b0;
            push(1'b0, r[0:127], r[0:191], r);
            f4 = if4.out_data; f6 = if6.out_data; f8 = if8.out_data;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            push(1'b1, f4, f6, f8);
            chk("roundtrip_nb4", 256'(if4.out_data), 256'(r[0:127]));
            chk("roundtrip_nb6", 256'(if6.out_data), 256'(r[0:191]));
            chk("roundtrip_nb8", 256'(if8.out_data), 256'(r));
            drain();
        end

        // Alternating forward/inverse stream.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            r = rnd256();
            push(k % 2 == 1, r[0:127], r[0:191], r);
        end
        drain();

        // Back-pressure at the full boundary.
        out_ready = 1'b0;
        r = rnd256(); push(1'b0, r[0:127], r[0:191], r);
        r = rnd256(); push(1'b1, r[0:127], r[0:191], r);
        chk("bp_level_full", 256'(if4.level), 256'(2));
        chk("bp_in_ready_full", 256'(if4.in_ready), 256'(0));
        held = if4.out_data;
        r = rnd256();
        in_valid = 1'b1; in_inv = 1'b0; d4 = r[0:127]; d6 = r[0:191]; d8 = r;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold_ready", 256'(if4.in_ready), 256'(0));
            chk("bp_stable", 256'(if4.out_data), 256'(held));
        end
        out_ready = 1'b1;
        chk("bp_no_comb_ready", 256'(if4.in_ready), 256'(0));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_ready_after_pop", 256'(if4.in_ready), 256'(1));
        chk("bp_level_after_pop", 256'(if4.level), 256'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_third_accepted", 256'(if4.level), 256'(2));
        drain();

        // Sustained streaming.
        p0 = pops;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            r = rnd256();
            in_inv = 1'($urandom); d4 = r[0:127]; d6 = r[0:191]; d8 = r;
            @(posedge clk); #1;
            chk("stream_level_le1", 256'(if4.level <= LW'(1)), 256'(1));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_count", 256'(pops - p0), 256'(100));
        drain();

        // Reset while full.
        out_ready = 1'b0;
        r = rnd256(); push(1'b0, r[0:127], r[0:191], r);
        r = rnd256(); push(1'b1, r[0:127], r[0:191], r);
        chk("mid_full", 256'(if4.level), 256'(2));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_state_checks("mid_reset");
        @(posedge clk); #1;
        chk("mid_ready_rise", 256'(if4.in_ready), 256'(1));
        r = rnd256();
        push(1'b1, r[0:127], r[0:191], r);
        g = permute(8, 1'b1, r);
        chk("mid_first_out", 256'(if8.out_data), 256'(g));
        chk("mid_first_valid", 256'(if4.out_valid), 256'(1));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/shift_rows_stream.md
# shift_rows_stream

Parametrised, registered ShiftRows/InvShiftRows stage for the AES/Rijndael datapath. It supports Rijndael block widths of 4, 6 and 8 columns and selects forward or inverse permutation on each beat. The stage has valid/ready handshakes on input and output and a small output FIFO, so it can sit between registered round stages without creating a combinational ready path. It replaces the fixed 128-bit combinational shift_rows in pipelined round datapaths.

## Interface
- NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
- DEPTH, 2, output FIFO entries; a power of two, at least 2.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept a beat.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the beat.
- in_data  in  [0:32*NB-1]  state, column-major; byte i = (row r, col c) with i = 4c+r, at bits [8i:8i+7].
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  [0:32*NB-1]  permuted state, same layout.
- out_inv  out  1  in_inv of the beat currently presented.
- level  out  [$clog2(DEPTH+1)-1:0]  FIFO occupancy.

## Operation
- Row shift offsets s(r):
  - NB=4 or NB=6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward: out(r,c) = in(r, (c+s(r)) mod NB).
- Inverse: out(r,c) = in(r, (c−s(r)+NB) mod NB).
- The modulo must be correct for NB=6, which is not a power of two. Compute the indices at elaboration time; do not use bit masking.
- The permutation is combinational on in_data. The result and in_inv are written into the FIFO at the write pointer.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Occupancy:
  - Push only: occupancy +1.
  - Pop only: occupancy −1.
  - Push and pop together: occupancy unchanged; both pointers advance.
- Read and write pointers wrap modulo DEPTH.
- out_data and out_inv always present the head entry. Outputs are registered or driven from FIFO storage, with no combinational path from in_data.
- in_ready = (level < DEPTH) & ~rst_q, where rst_q is rst delayed one cycle. in_ready never depends on out_ready in the same cycle.
- When full, a simultaneous out_ready does not admit a beat that cycle. in_ready rises the cycle after the pop.
- out_valid = (level != 0).
- out_data and out_inv must stay stable while out_valid=1 and out_ready=0.
- Data is never dropped or duplicated. Mode travels with its beat, so mixed forward/inverse streams are legal.

## Timing
- Reset (rst high at an edge):
  - level=0, pointers=0, out_valid=0, out_data=0, out_inv=0.
  - in_ready=0 during the cycle after any reset edge, then 1.
- Reset mid-stream discards all FIFO contents. No beat accepted before the reset is ever presented after it.
- Latency: a beat pushed at edge N into an empty FIFO has out_valid=1 in the cycle after edge N.
- Throughput: 1 beat per cycle sustained while out_ready=1.
- Full boundary:
  - Level reaches DEPTH at edge N, so in_ready=0 after N.
  - A pop at edge M gives in_ready=1 after M.
- Empty boundary: a push and pop cannot coincide when empty, because out_valid=0.

## Test plan
- NB=4, forward, in_data=0x000102030405060708090a0b0c0d0e0f → out_data=0x00050a0f04090e03080d02070c01060b, out_inv=0, one cycle after acceptance.
- NB=4, inverse of the previous output → 0x000102030405060708090a0b0c0d0e0f, out_inv=1. Run an alternating forward/inverse stream of 8 beats against a software model, checking per-beat mode.
- NB=6 and NB=8, bytes 0x00..0x17 and 0x00..0x1f:
  - NB=8 forward, column 0 = 00 05 0e 13.
  - For each NB, forward followed by inverse restores the input exactly.
  - Check all columns against the model, including wrap columns.
- Back-pressure, DEPTH=2, out_ready=0:
  - Push 2 beats → level=2, in_ready=0. A third beat is held on in_data and not accepted.
  - Raise out_ready for 1 cycle → beat 1 popped, in_ready=1 on the next cycle, beat 3 accepted.
  - Order is 1,2,3 and outputs are stable while stalled.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with random data → 100 beats out, in order, one per cycle, level ≤ 1.
- Reset mid-operation: FIFO full, assert rst for 1 cycle → out_valid=0, level=0, in_ready=0 for one cycle then 1. The first output after reset is the first beat pushed after reset.
